// File: rtl/peak_detection.sv
`default_nettype none
// ============================================================================
// Module   : peak_detection
// Purpose  : Streaming smoothed z-score peak detector on signed fixed-point
//            samples; pulses the value and index of each positive peak region.
// Revision : 1.0
// ============================================================================
module peak_detection #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LAG    = 64,
  parameter int Q          = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] new_sample,
  input  logic [5:0]                   lag,
  input  logic [15:0]                  threshold,
  input  logic [15:0]                  influence,
  input  logic                         en,
  output logic signed [DATA_WIDTH-1:0] filtered_value,
  output logic                         peak_point,
  output logic signed [DATA_WIDTH-1:0] peakx,
  output logic [13:0]                  peaky,
  output logic [7:0]                   peak_count_out
);

  localparam int c_SUM_W  = DATA_WIDTH + 7;
  localparam int c_DEV_W  = DATA_WIDTH + 6;
  localparam int c_EXT_W  = c_SUM_W + 1;
  localparam int c_PROD_W = 16 + c_DEV_W;
  localparam int c_CMP_W  = c_PROD_W + 2;
  localparam int c_BL_W   = DATA_WIDTH + Q + 3;
  localparam int c_INF_W  = Q + 1;
  localparam int c_PTR_W  = $clog2(MAX_LAG);
  localparam int c_ONE    = 1 << Q;

  localparam logic signed [c_BL_W-1:0] c_BL_MAX = c_BL_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [c_BL_W-1:0] c_BL_MIN = -c_BL_MAX - c_BL_W'(1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_WARM   = 2'd1;
  localparam logic [1:0] c_ST_DETECT = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic                        w_detect;
  logic                        w_warm;
  logic                        w_lag_latch;

  logic [5:0]                  r_lag;
  logic [c_PTR_W-1:0]          r_ptr;
  logic [6:0]                  r_warm_cnt;
  logic [13:0]                 r_idx;
  logic signed [c_SUM_W-1:0]   r_sum;
  logic [c_DEV_W-1:0]          r_devsum;
  logic signed [DATA_WIDTH-1:0] r_prev_filt;
  logic                        r_region_open;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [13:0]                 r_max_idx;

  logic signed [DATA_WIDTH-1:0] r_fbuf [0:MAX_LAG-1];
  logic [DATA_WIDTH-1:0]        r_dbuf [0:MAX_LAG-1];

  logic [5:0]                  w_lag_sel;
  logic [5:0]                  w_len;
  logic [2:0]                  w_k;
  logic                        w_warm_done;
  logic                        w_ptr_last;
  logic [c_PTR_W-1:0]          w_ptr_next;

  logic signed [c_SUM_W-1:0]   w_mean;
  logic [c_DEV_W-1:0]          w_dev;
  logic signed [c_EXT_W-1:0]   w_diff;
  logic [c_PROD_W-1:0]         w_prod;
  logic [c_PROD_W-1:0]         w_td;
  logic signed [c_CMP_W-1:0]   w_diff_c;
  logic signed [c_CMP_W-1:0]   w_td_c;
  logic                        w_sig_pos;
  logic                        w_sig_neg;

  logic [c_INF_W-1:0]          w_inf;
  logic [c_INF_W-1:0]          w_inf_rem;
  logic signed [c_BL_W-1:0]    w_blend;
  logic signed [c_BL_W-1:0]    w_blend_sh;
  logic signed [DATA_WIDTH-1:0] w_filt_blend;
  logic signed [DATA_WIDTH-1:0] w_filt;

  logic signed [c_EXT_W-1:0]   w_fdiff;
  logic [c_EXT_W-1:0]          w_fabs;
  logic signed [DATA_WIDTH:0]  w_wdiff;
  logic [DATA_WIDTH:0]         w_wabs;
  logic [DATA_WIDTH-1:0]       w_dent_det;
  logic [DATA_WIDTH-1:0]       w_dent_warm;
  logic [DATA_WIDTH-1:0]       w_dentry;

  logic signed [DATA_WIDTH-1:0] w_fold;
  logic [DATA_WIDTH-1:0]       w_dold;
  logic signed [c_SUM_W-1:0]   w_fold_ext;
  logic [c_DEV_W-1:0]          w_dold_ext;
  logic signed [c_SUM_W-1:0]   w_sum_next;
  logic [c_DEV_W-1:0]          w_devsum_next;

  // Phase sequencer: lag not yet latched, filling the window, detecting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (en) begin
          w_state_next = w_warm_done ? c_ST_DETECT : c_ST_WARM;
        end
      end
      c_ST_WARM: begin
        if (en && w_warm_done) begin
          w_state_next = c_ST_DETECT;
        end
      end
      c_ST_DETECT: w_state_next = c_ST_DETECT;
      default:     w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_detect    = 1'b0;
    w_warm      = 1'b0;
    w_lag_latch = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_warm      = 1'b1;
        w_lag_latch = en;
      end
      c_ST_WARM:   w_warm   = 1'b1;
      c_ST_DETECT: w_detect = 1'b1;
      default: begin
        w_detect    = 1'b0;
        w_warm      = 1'b0;
        w_lag_latch = 1'b0;
      end
    endcase
  end

  // The very first accepted sample must already see the lag it latches.
  assign w_lag_sel   = (r_state == c_ST_IDLE) ? lag : r_lag;
  assign w_len       = (w_lag_sel == 6'd0) ? 6'd1 : w_lag_sel;
  assign w_warm_done = ({1'b0, w_len} == (r_warm_cnt + 7'd1));
  assign w_ptr_last  = (r_ptr == c_PTR_W'(w_len - 6'd1));
  assign w_ptr_next  = w_ptr_last ? '0 : r_ptr + c_PTR_W'(1);

  always_comb begin
    w_k = 3'd0;
    for (int b = 0; b < 6; b++) begin
      if (w_len[b]) begin
        w_k = 3'(b);
      end
    end
  end

  assign w_mean   = r_sum >>> w_k;
  assign w_dev    = r_devsum >> w_k;
  assign w_diff   = c_EXT_W'(new_sample) - c_EXT_W'(w_mean);
  assign w_prod   = c_PROD_W'(threshold) * c_PROD_W'(w_dev);
  assign w_td     = w_prod >> Q;
  assign w_diff_c = c_CMP_W'(w_diff);
  assign w_td_c   = $signed(c_CMP_W'(w_td));

  assign w_sig_pos = w_detect && (w_diff_c > w_td_c);
  assign w_sig_neg = w_detect && (w_diff_c < -w_td_c);

  assign w_inf     = (influence > 16'(c_ONE)) ? c_INF_W'(c_ONE) : influence[Q:0];
  assign w_inf_rem = c_INF_W'(c_ONE) - w_inf;
  assign w_blend   = $signed(c_BL_W'(w_inf)) * c_BL_W'(new_sample)
                   + $signed(c_BL_W'(w_inf_rem)) * c_BL_W'(r_prev_filt);
  assign w_blend_sh = w_blend >>> Q;

  // A convex blend never leaves the sample range; clamping just makes that explicit.
  always_comb begin
    if (w_blend_sh > c_BL_MAX) begin
      w_filt_blend = c_BL_MAX[DATA_WIDTH-1:0];
    end else if (w_blend_sh < c_BL_MIN) begin
      w_filt_blend = c_BL_MIN[DATA_WIDTH-1:0];
    end else begin
      w_filt_blend = w_blend_sh[DATA_WIDTH-1:0];
    end
  end

  assign w_filt = (w_sig_pos || w_sig_neg) ? w_filt_blend : new_sample;

  assign w_fdiff    = c_EXT_W'(w_filt) - c_EXT_W'(w_mean);
  assign w_fabs     = w_fdiff[c_EXT_W-1] ? -w_fdiff : w_fdiff;
  assign w_dent_det = (w_fabs > c_EXT_W'({DATA_WIDTH{1'b1}})) ? '1 : w_fabs[DATA_WIDTH-1:0];

  assign w_wdiff     = (DATA_WIDTH+1)'(new_sample) - (DATA_WIDTH+1)'(r_prev_filt);
  assign w_wabs      = w_wdiff[DATA_WIDTH] ? -w_wdiff : w_wdiff;
  assign w_dent_warm = (r_idx == 14'd0) ? '0 :
                       (w_wabs > {1'b0, {DATA_WIDTH{1'b1}}}) ? '1 : w_wabs[DATA_WIDTH-1:0];

  assign w_dentry = w_detect ? w_dent_det : w_dent_warm;

  assign w_fold        = r_fbuf[r_ptr];
  assign w_dold        = r_dbuf[r_ptr];
  assign w_fold_ext    = w_detect ? c_SUM_W'(w_fold) : '0;
  assign w_dold_ext    = w_detect ? c_DEV_W'(w_dold) : '0;
  assign w_sum_next    = r_sum + c_SUM_W'(w_filt) - w_fold_ext;
  assign w_devsum_next = r_devsum + c_DEV_W'(w_dentry) - w_dold_ext;

  // Window storage; contents before the first fill are never read.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      r_fbuf[r_ptr] <= w_filt;
      r_dbuf[r_ptr] <= w_dentry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lag          <= '0;
      r_ptr          <= '0;
      r_warm_cnt     <= '0;
      r_idx          <= '0;
      r_sum          <= '0;
      r_devsum       <= '0;
      r_prev_filt    <= '0;
      r_region_open  <= 1'b0;
      r_max          <= '0;
      r_max_idx      <= '0;
      filtered_value <= '0;
      peak_point     <= 1'b0;
      peakx          <= '0;
      peaky          <= '0;
      peak_count_out <= '0;
    end else begin
      peak_point <= 1'b0;
      if (en) begin
        if (w_lag_latch) begin
          r_lag <= lag;
        end
        if (w_warm) begin
          r_warm_cnt <= r_warm_cnt + 7'd1;
        end
        r_idx          <= r_idx + 14'd1;
        r_ptr          <= w_ptr_next;
        r_sum          <= w_sum_next;
        r_devsum       <= w_devsum_next;
        r_prev_filt    <= w_filt;
        filtered_value <= w_filt;

        // Only positive excursions form regions; ties keep the earliest index.
        if (w_sig_pos) begin
          if (!r_region_open) begin
            r_region_open <= 1'b1;
            r_max         <= new_sample;
            r_max_idx     <= r_idx;
          end else if (new_sample > r_max) begin
            r_max     <= new_sample;
            r_max_idx <= r_idx;
          end
        end else if (r_region_open) begin
          r_region_open <= 1'b0;
          peak_point    <= 1'b1;
          peakx         <= r_max;
          peaky         <= r_max_idx;
          if (peak_count_out != 8'hFF) begin
            peak_count_out <= peak_count_out + 8'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peak_detection.sv
`default_nettype none
// ============================================================================
// Module   : tb_peak_detection
// Purpose  : Self-checking bench for peak_detection against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_peak_detection;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] new_sample;
  logic [5:0]         lag;
  logic [15:0]        threshold;
  logic [15:0]        influence;
  logic               en;
  logic signed [15:0] filtered_value;
  logic               peak_point;
  logic signed [15:0] peakx;
  logic [13:0]        peaky;
  logic [7:0]         peak_count_out;

  peak_detection #(.DATA_WIDTH(16), .MAX_LAG(64), .Q(8)) dut (
    .clk(clk), .rst(rst), .new_sample(new_sample), .lag(lag),
    .threshold(threshold), .influence(influence), .en(en),
    .filtered_value(filtered_value), .peak_point(peak_point),
    .peakx(peakx), .peaky(peaky), .peak_count_out(peak_count_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: window kept as FIFOs of filtered values and deviation entries.
  bit     m_latched;
  longint m_L;
  int     m_K;
  longint m_idx;
  longint m_prev;
  longint fq[$];
  longint dq[$];
  bit     m_open;
  longint m_max, m_maxidx;
  longint e_filt, e_px, e_py, e_cnt;
  bit     e_pp;
  longint cur_thr, cur_inf;

  int     pulses;
  longint last_pulse_idx;
  longint filt40;

  function automatic void model_reset();
    m_latched = 0; m_L = 1; m_K = 0; m_idx = 0; m_prev = 0;
    fq.delete(); dq.delete();
    m_open = 0; m_max = 0; m_maxidx = 0;
    e_filt = 0; e_px = 0; e_py = 0; e_cnt = 0; e_pp = 0;
  endfunction

  function automatic void model_step(input longint x, input int lag_in);
    longint s, d, mean, dev, diff, td, filt, entry, infc;
    int sig;
    if (!m_latched) begin
      m_latched = 1;
      m_L = (lag_in == 0) ? 1 : lag_in;
      m_K = 0;
      while ((longint'(1) << (m_K + 1)) <= m_L) m_K++;
    end
    infc = (cur_inf > 256) ? 256 : cur_inf;
    sig = 0;
    if (fq.size() < m_L) begin
      filt  = x;
      entry = (m_idx == 0) ? 0 : ((x - m_prev) < 0 ? m_prev - x : x - m_prev);
      if (entry > 65535) entry = 65535;
    end else begin
      s = 0; d = 0;
      foreach (fq[j]) s += fq[j];
      foreach (dq[j]) d += dq[j];
      mean = s >>> m_K;
      dev  = d >> m_K;
      diff = x - mean;
      td   = (cur_thr * dev) >> 8;
      if (diff > td) sig = 1;
      else if (diff < -td) sig = -1;
      filt  = (sig != 0) ? ((infc * x + (256 - infc) * m_prev) >>> 8) : x;
      entry = filt - mean;
      if (entry < 0) entry = -entry;
      if (entry > 65535) entry = 65535;
      void'(fq.pop_front());
      void'(dq.pop_front());
    end
    fq.push_back(filt);
    dq.push_back(entry);
    e_filt = filt;
    m_prev = filt;
    e_pp = 0;
    if (sig == 1) begin
      if (!m_open) begin
        m_open = 1; m_max = x; m_maxidx = m_idx;
      end else if (x > m_max) begin
        m_max = x; m_maxidx = m_idx;
      end
    end else if (m_open) begin
      m_open = 0; e_pp = 1; e_px = m_max; e_py = m_maxidx;
      if (e_cnt < 255) e_cnt++;
    end
    m_idx = (m_idx + 1) % 16384;
  endfunction

  task automatic cycle(input bit e, input longint x, input int lag_in);
    en = e;
    new_sample = 16'(x);
    lag = 6'(lag_in);
    @(posedge clk);
    #1;
    if (e) model_step(x, lag_in);
    else e_pp = 0;
    check("filt", filtered_value, e_filt);
    check("pp",   peak_point, e_pp);
    check("px",   peakx, e_px);
    check("py",   peaky, e_py);
    check("cnt",  peak_count_out, e_cnt);
    if (peak_point === 1'b1) begin
      pulses++;
      last_pulse_idx = m_idx - 1;
    end
    if (e && (m_idx - 1 == 40)) filt40 = filtered_value;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; en = 1'b1; lag = 6'(l);
    new_sample = 16'sd77;
    threshold = 16'(cur_thr); influence = 16'(cur_inf);
    repeat (2) @(posedge clk);
    #1;
    check("rst_filt", filtered_value, 0);
    check("rst_pp",   peak_point, 0);
    check("rst_px",   peakx, 0);
    check("rst_py",   peaky, 0);
    check("rst_cnt",  peak_count_out, 0);
    rst = 1'b0;
    model_reset();
    pulses = 0; last_pulse_idx = -1; filt40 = -9999;
  endtask

  function automatic longint sample_for(input int kind, input int i);
    case (kind)
      1: return (i == 40) ? 100 : 10;
      2: return (i == 40) ? 50 : (i == 41) ? 120 : (i == 42) ? 80 : 10;
      3: return (i == 40) ? -100 : 10;
      4: return (i >= 40 && (i % 40) == 0) ? 100 : 10;
      default: return 10;
    endcase
  endfunction

  task automatic run_stream(input int l, input int thr, input int inf, input int kind,
                            input int n, input int gap_at);
    cur_thr = thr; cur_inf = inf;
    do_reset(l);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 5; g++) cycle(1'b0, 999, l);
      end
      cycle(1'b1, sample_for(kind, i), l);
    end
  endtask

  task automatic run_random(input int l);
    bit     e;
    longint x;
    cur_thr = $urandom_range(0, 1024);
    cur_inf = $urandom_range(0, 400);
    do_reset(l);
    for (int i = 0; i < 500; i++) begin
      e = (i == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
      x = longint'($urandom_range(0, 200)) - 100;
      if ($urandom_range(0, 14) == 0) begin
        x = longint'($urandom_range(500, 5000));
        if ($urandom_range(0, 1) == 0) x = -x;
      end
      cycle(e, x, (i == 0) ? l : int'($urandom_range(0, 63)));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; new_sample = '0; lag = '0; threshold = '0; influence = '0;
    cur_thr = 512; cur_inf = 256;

    run_stream(32, 512, 256, 0, 200, -1);
    check("const_pulses", pulses, 0);
    check("const_filt", filtered_value, 10);

    run_stream(32, 512, 256, 1, 100, -1);
    check("spike_pulses", pulses, 1);
    check("spike_at", last_pulse_idx, 41);
    check("spike_px", peakx, 100);
    check("spike_py", peaky, 40);
    check("spike_cnt", peak_count_out, 1);

    run_stream(32, 512, 256, 2, 100, -1);
    check("multi_pulses", pulses, 1);
    check("multi_px", peakx, 120);
    check("multi_py", peaky, 41);
    check("multi_cnt", peak_count_out, 1);

    run_stream(32, 512, 256, 3, 100, -1);
    check("neg_pulses", pulses, 0);
    check("neg_cnt", peak_count_out, 0);

    run_stream(32, 512, 256, 2, 100, 20);
    check("gap20_px", peakx, 120);
    check("gap20_py", peaky, 41);
    run_stream(32, 512, 256, 2, 100, 42);
    check("gap42_pulses", pulses, 1);
    check("gap42_px", peakx, 120);
    check("gap42_py", peaky, 41);
    check("gap42_cnt", peak_count_out, 1);

    run_stream(32, 512, 128, 1, 100, -1);
    check("inf128_filt40", filt40, 55);
    check("inf128_px", peakx, 100);

    run_stream(32, 512, 256, 4, 40 * 301, -1);
    check("sat_pulses", pulses, 300);
    check("sat_cnt", peak_count_out, 255);

    run_random(0);
    run_random(1);
    run_random(63);
    for (int r = 0; r < 7; r++) run_random(int'($urandom_range(1, 63)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peak_detection.md
Name: peak_detection

Overview:
- Streaming smoothed-z-score peak detector for signed Q8.8 samples; one sample is accepted per `clk` while `en`=1.
- Keeps a circular window of the last `lag` filtered samples and compares each new sample against the window mean ± threshold·deviation.
- Emits a one-cycle pulse with the value and index of each positive peak region.
- Sits after the sample front-end and feeds peak-reporting logic.

Parameters:
- DATA_WIDTH, 16, sample/output width (signed Q(DATA_WIDTH−Q).Q).
- MAX_LAG, 64, depth of the window buffers.
- Q, 8, fractional bits of `threshold` and `influence`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- new_sample  in  DATA_WIDTH  signed input sample.
- lag  in  6  window length L, 1..MAX_LAG−1.
- threshold  in  16  unsigned Q8.8 z multiplier.
- influence  in  16  unsigned Q8.8 weight of flagged samples; values above 1<<Q are clamped to 1<<Q.
- en  in  1  sample valid; one sample per cycle.
- filtered_value  out  DATA_WIDTH  signed last filtered sample.
- peak_point  out  1  one-cycle peak pulse.
- peakx  out  DATA_WIDTH  signed value of last peak.
- peaky  out  14  sample index of last peak.
- peak_count_out  out  8  number of peaks reported, saturating at 255.

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high. Reset clears all outputs, idx, warm-up count, write pointer, sum, devsum, prev_filt, region state and latched lag to 0. Buffer RAM contents need not be cleared.
- Lag latching: `lag` is latched on the first `en` cycle after reset; later changes are ignored until the next reset. Let K = floor(log2(L)); lag=0 is treated as 1. Mean = sum>>>K and dev = devsum>>K (exact for power-of-two L).
- Sample index: idx is a 14-bit counter. The first accepted sample has index 0; idx increments per accepted sample and wraps 16383→0.
- Latency: all outputs are registered and update at the same edge that accepts the sample, computed from `new_sample` and pre-edge state. When `en`=0, state holds and `peak_point` returns to 0.
- Warm-up (first L accepted samples):
  - filt = x, written to fbuf[ptr]; sum += x.
  - Dev entry = |x − prev_filt| (0 for index 0), written to dbuf[ptr]; devsum += entry.
  - No detection; signal = 0.
- Detect (afterwards), using pre-insertion mean and dev:
  - diff = x − mean (17-bit signed).
  - td = (threshold·dev)>>Q.
  - signal = +1 if diff > td; −1 if diff < −td; else 0. Comparisons are strict.
  - If signal ≠ 0: filt = (inf·x + ((1<<Q)−inf)·prev_filt)>>>Q. Otherwise filt = x.
  - Dev entry = |filt − mean|, saturated to DATA_WIDTH.
  - sum += filt − fbuf[ptr]; devsum += entry − dbuf[ptr]; overwrite both slots.
- Pointer: ptr wraps at L−1→0.
- Accumulator widths: sum is signed DATA_WIDTH+7 bits; devsum is unsigned DATA_WIDTH+6 bits. Neither may overflow.
- filtered_value: takes filt on every accepted sample; prev_filt = filt.
- Peak regions (only +1 opens a region):
  - On signal=+1 with no region open: open region; max = x, maxidx = idx.
  - Within a region: if x > max, update max and maxidx. Ties keep the earlier index.
  - On signal 0 or −1 with a region open: close region, peak_point = 1 for one cycle, peakx = max, peaky = maxidx, count++ (saturating).
  - Negative signals never produce peaks.
  - A region still open at reset is discarded.
- peakx and peaky hold until the next peak.
- Reset mid-operation: returns to warm-up with index 0.

Test Plan:
- Reset: assert rst for 2 cycles with en=1 → all outputs 0, peak_count_out=0.
- Constant input: L=32, threshold=512, influence=256, input 10 for 200 samples → filtered_value=10, peak_point never asserts.
- Single spike: as above but index 40 = 100, others 10.
  - Index 40: mean=10, dev=0 → signal +1.
  - Index 41: mean=12, dev=2, td=4, diff=−2 → region closes; peak_point pulse at the edge accepting index 41 with peakx=100, peaky=40, peak_count_out=1.
- Multi-sample region: indices 40..42 = 50, 120, 80, otherwise 10 (same L, threshold, influence) → exactly one pulse with peakx=120, peaky=41, peak_count_out=1.
- Negative spike / gaps:
  - Index 40 = −100 → no pulse.
  - Drop en for 5 cycles mid-stream → idx and state frozen; results identical to the gapless stream.
- Influence and saturation:
  - Influence 128 with the spike → filtered_value at index 40 = 55.
  - 300 spikes spaced 40 samples → peak_count_out saturates at 255.
